cache_miss_handler: RTL and testbench
=====================================

// Module: cache_miss_handler
// PURPOSE
//  Per-set miss/refill sequencer for the 4-way set-associative data cache.
//  Consumes the lookup verdict (Hit, victim way S) from the LRU replacement logic and drives its Init strobe.
//  On a miss: writes back a dirty victim line if needed, refills the line from memory beat by beat, then releases the pipeline stall.
//  Sits between the MEM pipeline stage and the memory bus handshake.
// PARAMETERS
//  ADDR_W     32  byte address width
//  WORD_W     32  data beat width
//  BEATS       4  words per cache line (power of 2, >=2)
//  TAG_W      26  tag width (ADDR_W - index - offset bits)
// PORTS
//  CLK         in   1       system clock, all state on posedge
//  Reset       in   1       asynchronous, active-high reset
//  Req         in   1       MEM stage cache access valid this cycle
//  Addr        in   ADDR_W  access address (line base = Addr with offset bits zeroed)
//  Hit         in   1       any way tag-matched (from replacement logic)
//  S           in   2       selected way: hit way on hit, victim on miss
//  VictimDirty in   1       dirty bit of way S in the indexed set
//  VictimTag   in   TAG_W   tag of way S in the indexed set
//  MemReady    in   1       memory accepted/returned current beat
//  Init        out  1       one-cycle lookup strobe to replacement logic
//  Stall       out  1       hold pipeline; high from miss detect to DONE
//  MemReq      out  1       memory beat request valid
//  MemWE       out  1       1 = writeback beat, 0 = refill read beat
//  MemAddr     out  ADDR_W  beat address
//  WayWE       out  1       write refill beat into way VictimWay
//  VictimWay   out  2       way latched at miss detection
//  Beat        out  log2(BEATS) current word index within line
// BEHAVIOUR
//  States: IDLE, LOOKUP, WRITEBACK, REFILL, DONE.
//  Reset (async): state=IDLE; every output 0; latched way/addr/tag = 0.
//  IDLE: Req=1 -> LOOKUP; Init=1 only in the LOOKUP cycle (exactly one cycle per Req).
//  LOOKUP: Hit=1 -> IDLE, Stall=0 (hit costs 1 cycle).
//   Hit=0: latch S->VictimWay, Addr line base, VictimTag; Stall=1 from this cycle;
//   next = WRITEBACK if VictimDirty (feature-gated), else REFILL.
//  WRITEBACK: MemReq=1, MemWE=1, MemAddr={VictimTag,index,Beat,2'b00}.
//   Beat advances only on MemReady; on MemReady at Beat=BEATS-1 -> REFILL, Beat wraps to 0.
//  REFILL: MemReq=1, MemWE=0, MemAddr={lineaddr tag/index,Beat,2'b00}.
//   WayWE = MemReady (same cycle); Beat advances on MemReady; last beat -> DONE.
//  DONE: Stall=1 for this cycle, then -> IDLE; the pipeline replays the access and hits.
//  Req ignored outside IDLE. MemReady ignored unless MemReq=1.
//  MemReq stays high, and MemAddr stable, until MemReady; no beat is skipped or repeated.
//  Reset mid-transfer: abort immediately, MemReq drops, no WayWE; line content is undefined and the refilled way is not marked valid.
//  Beat counter is exactly log2(BEATS) bits; wrap-around at BEATS-1 is natural overflow.
// CONFIGURATION
//  CACHE_WRITEBACK_EN defined: dirty victims are written back before refill, as above.
//  CACHE_WRITEBACK_EN undefined: write-through cache; VictimDirty/VictimTag ignored, WRITEBACK unreachable, MemWE tied 0.
// STRUCTURE
//  Shared package cache_defs.vh: state encodings, BEATS, offset/index/tag field widths, line-address slice macros.
//  One sub-module cache_beat_counter: enable/clear counter with terminal-count flag, built on flopenrc.
//  FSM state register is async-reset; next-state logic is a single combinational block.
// TESTING
//  Hit: Req=1,Hit=1 -> Init=1 for 1 cycle, Stall never high, back in IDLE after 2 cycles.
//  Clean miss: Hit=0,S=2,VictimDirty=0,Addr=0x0000_1234, MemReady=1 always -> 4 refill reads at 0x1230,0x1234,0x1238,0x123C; WayWE 4 cycles; VictimWay=2; Stall 6 cycles.
//  Dirty miss (CACHE_WRITEBACK_EN): VictimTag from address 0x0000_5230 -> writes at 0x5230..0x523C, then reads at 0x1230..0x123C; MemWE 1->0 boundary exactly at beat 4.
//  Back-pressure: MemReady low 3 cycles per beat -> MemAddr held constant while waiting, WayWE only on ready cycles, total 16 refill cycles.
//  Reset asserted at REFILL Beat=2 -> same-cycle MemReq=0, WayWE=0, Stall=0; next Req starts a fresh LOOKUP.
//  Build without CACHE_WRITEBACK_EN, VictimDirty=1 -> no MemWE=1 cycles; goes straight to REFILL.

Source files
------------

// File: rtl/cache_miss_handler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_handler_pkg
//  Description : Shared definitions for the cache miss/refill sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package cache_miss_handler_pkg;

    localparam int c_DEF_ADDR_W = 32;
    localparam int c_DEF_WORD_W = 32;
    localparam int c_DEF_BEATS  = 4;
    localparam int c_DEF_TAG_W  = 26;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Offset bits of a line address: word select plus byte-within-word.
    function automatic int off_bits(input int beats, input int word_w);
        return $clog2(beats) + $clog2(word_w / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_miss_handler_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_handler_beat_counter
//  Description : Enable/clear beat counter with terminal-count flag.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_miss_handler_beat_counter #(
    parameter int BEATS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic                       i_clr,
    output logic [$clog2(BEATS)-1:0]   o_count,
    output logic                       o_tc
);

    localparam int c_BEAT_W = $clog2(BEATS);

    logic [c_BEAT_W-1:0] r_count;

    // Wrap from BEATS-1 to 0 is plain overflow of the counter width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + c_BEAT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == c_BEAT_W'(BEATS - 1));

endmodule
`default_nettype wire

// File: rtl/cache_miss_handler.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_handler
//  Description : Per-set miss/refill sequencer for the 4-way data cache.
//                Define CACHE_WRITEBACK_EN to write back dirty victims.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int WORD_W = c_DEF_WORD_W,
    parameter int BEATS  = c_DEF_BEATS,
    parameter int TAG_W  = c_DEF_TAG_W
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       Req,
    input  logic [ADDR_W-1:0]          Addr,
    input  logic                       Hit,
    input  logic [1:0]                 S,
    input  logic                       VictimDirty,
    input  logic [TAG_W-1:0]           VictimTag,
    input  logic                       MemReady,
    output logic                       Init,
    output logic                       Stall,
    output logic                       MemReq,
    output logic                       MemWE,
    output logic [ADDR_W-1:0]          MemAddr,
    output logic                       WayWE,
    output logic [1:0]                 VictimWay,
    output logic [$clog2(BEATS)-1:0]   Beat
);

    localparam int c_BEAT_W = $clog2(BEATS);
    localparam int c_OFF_W  = off_bits(BEATS, WORD_W);
    localparam int c_BYTE_W = c_OFF_W - c_BEAT_W;
    localparam int c_LINE_W = ADDR_W - c_OFF_W;
    localparam int c_IDX_W  = c_LINE_W - TAG_W;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_way;
    logic [c_LINE_W-1:0] r_line;
    logic                w_miss;
    logic                w_init;
    logic                w_stall;
    logic                w_memreq;
    logic                w_memwe;
    logic                w_waywe;
    logic [ADDR_W-1:0]   w_memaddr;
    logic [c_BEAT_W-1:0] w_beat;
    logic                w_tc;

    assign w_miss = (r_state == ST_LOOKUP) && !Hit;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_way  <= '0;
            r_line <= '0;
        end else if (w_miss) begin
            r_way  <= S;
            r_line <= Addr[ADDR_W-1:c_OFF_W];
        end
    end

`ifdef CACHE_WRITEBACK_EN
    logic [TAG_W-1:0] r_vtag;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_vtag <= '0;
        end else if (w_miss) begin
            r_vtag <= VictimTag;
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, Addr[c_OFF_W-1:0]};
`else
    logic w_unused;
    assign w_unused = &{1'b0, Addr[c_OFF_W-1:0], VictimDirty, VictimTag};
`endif

    cache_miss_handler_beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk     (CLK),
        .rst     (Reset),
        .i_en    (w_memreq & MemReady),
        .i_clr   (r_state == ST_LOOKUP),
        .o_count (w_beat),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_next   = r_state;
        w_init   = 1'b0;
        w_stall  = 1'b0;
        w_memreq = 1'b0;
        w_memwe  = 1'b0;
        w_waywe  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Req) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_init = 1'b1;
                if (Hit) begin
                    w_next = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
`ifdef CACHE_WRITEBACK_EN
                    w_next  = VictimDirty ? ST_WRITEBACK : ST_REFILL;
`else
                    w_next  = ST_REFILL;
`endif
                end
            end
`ifdef CACHE_WRITEBACK_EN
            ST_WRITEBACK: begin
                w_stall  = 1'b1;
                w_memreq = 1'b1;
                w_memwe  = 1'b1;
                if (MemReady && w_tc) begin
                    w_next = ST_REFILL;
                end
            end
`endif
            ST_REFILL: begin
                w_stall  = 1'b1;
                w_memreq = 1'b1;
                w_waywe  = MemReady;
                if (MemReady && w_tc) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_stall = 1'b1;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Beat address is rebuilt each cycle from latched fields, so it holds while waiting.
    always_comb begin
        w_memaddr = '0;
        if (r_state == ST_REFILL) begin
            w_memaddr = {r_line, w_beat, {c_BYTE_W{1'b0}}};
        end
`ifdef CACHE_WRITEBACK_EN
        else if (r_state == ST_WRITEBACK) begin
            w_memaddr = {r_vtag, r_line[c_IDX_W-1:0], w_beat, {c_BYTE_W{1'b0}}};
        end
`endif
    end

    assign Init      = w_init;
    assign Stall     = w_stall;
    assign MemReq    = w_memreq;
    assign MemWE     = w_memwe;
    assign MemAddr   = w_memaddr;
    assign WayWE     = w_waywe;
    assign VictimWay = r_way;
    assign Beat      = w_beat;

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_miss_handler
//  Description : Directed and randomized checks of cache_miss_handler against
//                a beat-list reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_miss_handler;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int BEATS  = 4;
    localparam int TAG_W  = 26;

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic              Req = 1'b0;
    logic [ADDR_W-1:0] Addr = '0;
    logic              Hit = 1'b0;
    logic [1:0]        S = '0;
    logic              VictimDirty = 1'b0;
    logic [TAG_W-1:0]  VictimTag = '0;
    logic              MemReady = 1'b0;
    logic              Init;
    logic              Stall;
    logic              MemReq;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic              WayWE;
    logic [1:0]        VictimWay;
    logic [1:0]        Beat;

    int total = 0;
    int bad   = 0;
    int cyc;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        int          beat;
    } beat_t;

    beat_t q[$];

    always #5 CLK = ~CLK;

    cache_miss_handler #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .BEATS  (BEATS),
        .TAG_W  (TAG_W)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Req         (Req),
        .Addr        (Addr),
        .Hit         (Hit),
        .S           (S),
        .VictimDirty (VictimDirty),
        .VictimTag   (VictimTag),
        .MemReady    (MemReady),
        .Init        (Init),
        .Stall       (Stall),
        .MemReq      (MemReq),
        .MemWE       (MemWE),
        .MemAddr     (MemAddr),
        .WayWE       (WayWE),
        .VictimWay   (VictimWay),
        .Beat        (Beat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected memory traffic of one miss: optional writeback beats, then refill beats.
    function automatic int wb_enabled();
`ifdef CACHE_WRITEBACK_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    task automatic run_hit(input logic [1:0] way);
        Req = 1'b1; Hit = 1'b0;
        @(negedge CLK);
        chk("hit_idle_init", Init, 0);
        @(posedge CLK); #1;
        Req = 1'b0; Hit = 1'b1; S = way; Addr = $urandom; MemReady = 1'($urandom);
        @(negedge CLK);
        chk("hit_init", Init, 1);
        chk("hit_stall", Stall, 0);
        chk("hit_memreq", MemReq, 0);
        @(posedge CLK); #1;
        Hit = 1'($urandom); MemReady = 1'($urandom);
        @(negedge CLK);
        chk("hit_after_init", Init, 0);
        chk("hit_after_stall", Stall, 0);
        chk("hit_after_memreq", MemReq, 0);
        @(posedge CLK); #1;
        Hit = 1'b0; MemReady = 1'b0;
    endtask

    task automatic run_miss(input logic [31:0] addr, input logic [1:0] way, input bit dirty,
                            input logic [TAG_W-1:0] vtag, input int mode, output int cycles);
        logic [31:0] base;
        int          waited;
        bit          rdy;
        beat_t       e;
        base   = addr & 32'hFFFF_FFF0;
        waited = 0;
        q.delete();
        if (dirty && wb_enabled() != 0) begin
            for (int b = 0; b < BEATS; b++)
                q.push_back('{1'b1, (32'(vtag) << 6) | (addr & 32'h30) | 32'(b * 4), b});
        end
        for (int b = 0; b < BEATS; b++)
            q.push_back('{1'b0, base + 32'(b * 4), b});

        Req = 1'b1; Hit = 1'($urandom);
        @(negedge CLK);
        chk("miss_idle_stall", Stall, 0);
        @(posedge CLK); #1;
        Req = 1'($urandom); Hit = 1'b0; S = way; Addr = addr;
        VictimDirty = dirty; VictimTag = vtag; MemReady = 1'($urandom);
        @(negedge CLK);
        chk("lookup_init", Init, 1);
        chk("lookup_stall", Stall, 1);
        chk("lookup_memreq", MemReq, 0);
        @(posedge CLK); #1;

        cycles = 0;
        while (q.size() > 0 && cycles < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (waited == 3);
            endcase
            MemReady = rdy; Req = 1'($urandom); Hit = 1'($urandom); S = 2'($urandom);
            Addr = $urandom; VictimDirty = 1'($urandom); VictimTag = TAG_W'($urandom);
            e = q[0];
            @(negedge CLK);
            chk("xfer_stall", Stall, 1);
            chk("xfer_init", Init, 0);
            chk("xfer_memreq", MemReq, 1);
            chk("xfer_memwe", MemWE, 32'(e.we));
            chk("xfer_memaddr", MemAddr, e.addr);
            chk("xfer_waywe", WayWE, 32'(rdy && !e.we));
            chk("xfer_way", VictimWay, way);
            chk("xfer_beat", Beat, e.beat);
            if (rdy) begin
                void'(q.pop_front());
                waited = 0;
            end else begin
                waited++;
            end
            cycles++;
            @(posedge CLK); #1;
        end
        if (q.size() != 0)
            chk("xfer_timeout", q.size(), 0);

        Req = 1'b0; MemReady = 1'($urandom); Hit = 1'($urandom);
        @(negedge CLK);
        chk("done_stall", Stall, 1);
        chk("done_memreq", MemReq, 0);
        chk("done_waywe", WayWE, 0);
        @(posedge CLK); #1;
        MemReady = 1'b0; Hit = 1'b0;
        @(negedge CLK);
        chk("post_stall", Stall, 0);
        chk("post_memreq", MemReq, 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_init", Init, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_memreq", MemReq, 0);
        chk("rst_memwe", MemWE, 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_waywe", WayWE, 0);
        chk("rst_way", VictimWay, 0);
        chk("rst_beat", Beat, 0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;

        run_hit(2'd1);

        run_miss(32'h0000_1234, 2'd2, 1'b0, '0, 0, cyc);
        chk("clean_cycles", cyc, 4);

        run_miss(32'h0000_1234, 2'd1, 1'b1, TAG_W'(32'h0000_5230 >> 6), 0, cyc);
        chk("dirty_cycles", cyc, (wb_enabled() != 0) ? 8 : 4);

        run_miss(32'h0000_1234, 2'd3, 1'b0, '0, 2, cyc);
        chk("bp_cycles", cyc, 16);

        run_miss(32'hABCD_0128, 2'd0, 1'b1, TAG_W'(32'h0000_7700 >> 6), 2, cyc);
        chk("bp_dirty_cycles", cyc, (wb_enabled() != 0) ? 32 : 16);

        // Abort in the middle of a refill.
        Req = 1'b1;
        @(posedge CLK); #1;
        Req = 1'b0; Hit = 1'b0; S = 2'd2; Addr = 32'h0000_1234; VictimDirty = 1'b0; MemReady = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        chk("abort_pre_memreq", MemReq, 1);
        chk("abort_pre_beat", Beat, 2);
        chk("abort_pre_addr", MemAddr, 32'h0000_1238);
        Reset = 1'b1;
        #1;
        chk("abort_memreq", MemReq, 0);
        chk("abort_waywe", WayWE, 0);
        chk("abort_stall", Stall, 0);
        chk("abort_beat", Beat, 0);
        chk("abort_way", VictimWay, 0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;
        MemReady = 1'b0;
        run_hit(2'd0);

        for (int n = 0; n < 14; n++) begin
            logic [31:0] ra;
            int          rmode;
            bit          rd;
            int          nb;
            ra    = $urandom;
            rmode = $urandom_range(0, 2);
            rd    = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                run_hit(2'($urandom));
            end else begin
                run_miss(ra, 2'($urandom), rd, TAG_W'($urandom), rmode, cyc);
                nb = (rd && wb_enabled() != 0) ? 2 * BEATS : BEATS;
                if (rmode == 0)
                    chk("rand_cycles", cyc, nb);
                else if (rmode == 2)
                    chk("rand_bp_cycles", cyc, 4 * nb);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
